// File: rtl/calc_pkg.sv
// Shared funct codes and sequencer state encoding for the calculator datapath.
package calc_pkg;

  localparam logic [2:0] FUNCT_ADD     = 3'b000;
  localparam logic [2:0] FUNCT_SUB     = 3'b001;
  localparam logic [2:0] FUNCT_ACC_ADD = 3'b010;
  localparam logic [2:0] FUNCT_ACC_SUB = 3'b011;
  localparam logic [2:0] FUNCT_MUL     = 3'b100;
  localparam logic [2:0] FUNCT_HALT    = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MUL_START,
    ST_MUL_WAIT,
    ST_HALT
  } state_t;

  // True for the single-cycle add/subtract family that goes through EXEC.
  function automatic logic is_addsub(input logic [2:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
           (funct == FUNCT_ACC_ADD) || (funct == FUNCT_ACC_SUB);
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// Cycle counter that bounds how long the sequencer waits for the multiplier.
module mul_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT - 1));

  // Count enabled cycles, holding at the expiry value so it cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Control sequencer: fetches funct codes, drives the add/sub and multiply
// datapath controls, tracks retired instructions and a sticky error flag.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             instr_valid,
  input  logic [2:0]       instr_funct,
  output logic             instr_ready,
  input  logic             mul_done,
  input  logic             clr_err,
  output logic             pc_en,
  output logic             sign_ctrl,
  output logic             store_prev_ctrl,
  output logic             op_sel,
  output logic             mul_start,
  output logic             acc_wr_en,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, state_next;
  logic [2:0] funct_q;
  logic       wd_clear, wd_enable, wd_expired;
  logic       count_inc, err_set;

  mul_watchdog #(.TIMEOUT(MUL_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Capture the funct code on every FETCH handshake for use in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) funct_q <= '0;
    else if (state == ST_FETCH && instr_valid) funct_q <= instr_funct;
  end

  // Retired-instruction counter, wrapping naturally at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instr_count <= '0;
    else if (count_inc) instr_count <= instr_count + CNT_W'(1);
  end

  // Sticky error: a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end

  // Next-state and control decode; every output defaults low.
  always_comb begin
    state_next      = state;
    instr_ready     = 1'b0;
    pc_en           = 1'b0;
    sign_ctrl       = 1'b0;
    store_prev_ctrl = 1'b0;
    op_sel          = 1'b0;
    mul_start       = 1'b0;
    acc_wr_en       = 1'b0;
    busy            = 1'b0;
    halted          = 1'b0;
    wd_clear        = 1'b0;
    wd_enable       = 1'b0;
    count_inc       = 1'b0;
    err_set         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        busy        = 1'b1;
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (is_addsub(instr_funct))         state_next = ST_EXEC;
          else if (instr_funct == FUNCT_MUL)  state_next = ST_MUL_START;
          else if (instr_funct == FUNCT_HALT) state_next = ST_HALT;
          else begin
            err_set = 1'b1;
            pc_en   = 1'b1;
          end
        end else if (!run) begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        busy            = 1'b1;
        acc_wr_en       = 1'b1;
        pc_en           = 1'b1;
        sign_ctrl       = (funct_q == FUNCT_SUB) || (funct_q == FUNCT_ACC_SUB);
        store_prev_ctrl = (funct_q == FUNCT_ADD) || (funct_q == FUNCT_SUB);
        count_inc       = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_MUL_START: begin
        busy       = 1'b1;
        mul_start  = 1'b1;
        wd_clear   = 1'b1;
        state_next = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        busy      = 1'b1;
        wd_enable = 1'b1;
        if (mul_done) begin
          acc_wr_en  = 1'b1;
          op_sel     = 1'b1;
          pc_en      = 1'b1;
          count_inc  = 1'b1;
          state_next = ST_FETCH;
        end else if (wd_expired) begin
          err_set    = 1'b1;
          pc_en      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!run) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        instr_valid = 1'b0;
  logic [2:0]  instr_funct = 3'b000;
  logic        mul_done = 1'b0;
  logic        clr_err = 1'b0;
  logic        instr_ready, pc_en, sign_ctrl, store_prev_ctrl, op_sel;
  logic        mul_start, acc_wr_en, busy, halted, err;
  logic [15:0] instr_count;

  int check_count = 0;
  int pass_count  = 0;
  int bad;

  calc_sequencer #(.MUL_TIMEOUT(64), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .instr_valid     (instr_valid),
    .instr_funct     (instr_funct),
    .instr_ready     (instr_ready),
    .mul_done        (mul_done),
    .clr_err         (clr_err),
    .pc_en           (pc_en),
    .sign_ctrl       (sign_ctrl),
    .store_prev_ctrl (store_prev_ctrl),
    .op_sel          (op_sel),
    .mul_start       (mul_start),
    .acc_wr_en       (acc_wr_en),
    .busy            (busy),
    .halted          (halted),
    .err             (err),
    .instr_count     (instr_count)
  );

  always #5 clk = ~clk;

  // Packed view of the control outputs, in the same order as ctl().
  function automatic logic [9:0] outs();
    return {instr_ready, pc_en, sign_ctrl, store_prev_ctrl, op_sel,
            mul_start, acc_wr_en, busy, halted, err};
  endfunction

  function automatic logic [9:0] ctl(input logic rdy, pc, sgn, sto, op,
                                     ms, wr, bsy, hlt, er);
    return {rdy, pc, sgn, sto, op, ms, wr, bsy, hlt, er};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drive inputs just after the falling edge, then settle before checking.
  task automatic applyStimulus(input logic r, v, input logic [2:0] f,
                               input logic d, c);
    @(negedge clk);
    run = r; instr_valid = v; instr_funct = f; mul_done = d; clr_err = c;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL sim_timeout: observed no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ctl", outs(), 0);
    checkOutput("reset_count", instr_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // ADD then SUB; run drops during the SUB execute cycle
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("idle", outs(), 0);
    applyStimulus(1, 1, FUNCT_ADD, 0, 0);
    checkOutput("fetch_add", outs(), ctl(1,0,0,0,0,0,0,1,0,0));
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("exec_add", outs(), ctl(0,1,0,1,0,0,1,1,0,0));
    applyStimulus(1, 1, FUNCT_SUB, 0, 0);
    applyStimulus(0, 0, FUNCT_ADD, 0, 0);
    checkOutput("exec_sub", outs(), ctl(0,1,1,1,0,0,1,1,0,0));

    // MUL answered five cycles after the start pulse
    applyStimulus(1, 1, FUNCT_MUL, 0, 0);
    checkOutput("count_addsub", instr_count, 2);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("mul_start", outs(), ctl(0,0,0,0,0,1,0,1,0,0));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, FUNCT_ADD, 0, 0);
      if (outs() !== ctl(0,0,0,0,0,0,0,1,0,0)) bad++;
    end
    checkOutput("mul_wait_quiet", bad, 0);
    applyStimulus(1, 0, FUNCT_ADD, 1, 0);
    checkOutput("mul_done", outs(), ctl(0,1,0,0,1,0,1,1,0,0));

    // MUL with no response: abort after 64 wait cycles
    applyStimulus(1, 1, FUNCT_MUL, 0, 0);
    checkOutput("fetch_after_mul", outs(), ctl(1,0,0,0,0,0,0,1,0,0));
    checkOutput("count_mul", instr_count, 3);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1, 0, FUNCT_ADD, 0, 0);
      if (outs() !== ctl(0,0,0,0,0,0,0,1,0,0)) bad++;
    end
    checkOutput("timeout_quiet", bad, 0);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("timeout_cycle", outs(), ctl(0,1,0,0,0,0,0,1,0,0));
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("err_after_timeout", outs(), ctl(1,0,0,0,0,0,0,1,0,1));
    checkOutput("count_timeout", instr_count, 3);
    applyStimulus(1, 0, FUNCT_ADD, 0, 1);

    // mul_done arriving on the expiry cycle completes without error
    applyStimulus(1, 1, FUNCT_MUL, 0, 0);
    checkOutput("err_cleared", outs(), ctl(1,0,0,0,0,0,0,1,0,0));
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1, 0, FUNCT_ADD, 0, 0);
      if (outs() !== ctl(0,0,0,0,0,0,0,1,0,0)) bad++;
    end
    checkOutput("boundary_quiet", bad, 0);
    applyStimulus(1, 0, FUNCT_ADD, 1, 0);
    checkOutput("done_on_timeout", outs(), ctl(0,1,0,0,1,0,1,1,0,0));

    // Illegal codes; clear collides with the second error
    applyStimulus(1, 1, 3'b101, 0, 0);
    checkOutput("illegal_101", outs(), ctl(1,1,0,0,0,0,0,1,0,0));
    checkOutput("count_boundary", instr_count, 4);
    applyStimulus(1, 1, 3'b110, 0, 1);
    checkOutput("illegal_110_clr", outs(), ctl(1,1,0,0,0,0,0,1,0,1));
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("err_sticky", outs(), ctl(1,0,0,0,0,0,0,1,0,1));
    checkOutput("count_illegal", instr_count, 4);
    applyStimulus(1, 0, FUNCT_ADD, 0, 1);

    // HALT, hold with run high, then drop run
    applyStimulus(1, 1, FUNCT_HALT, 0, 0);
    checkOutput("fetch_halt", outs(), ctl(1,0,0,0,0,0,0,1,0,0));
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("halt_run", outs(), ctl(0,0,0,0,0,0,0,0,1,0));
    applyStimulus(0, 0, FUNCT_ADD, 0, 0);
    checkOutput("halt_drop", outs(), ctl(0,0,0,0,0,0,0,0,1,0));
    applyStimulus(0, 0, FUNCT_ADD, 0, 0);
    checkOutput("idle_after_halt", outs(), 0);
    checkOutput("count_halt", instr_count, 4);

    // Reset in the middle of a multiply wait
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    applyStimulus(1, 1, FUNCT_MUL, 0, 0);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("mul_wait_pre_reset", outs(), ctl(0,0,0,0,0,0,0,1,0,0));
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    #1;
    checkOutput("reset_mid_mul", outs(), 0);
    checkOutput("reset_mid_count", instr_count, 0);
    applyStimulus(0, 0, FUNCT_ADD, 1, 0);
    checkOutput("reset_hold", outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    mul_done = 1'b1;
    #1;
    checkOutput("stale_done", outs(), 0);
    applyStimulus(0, 0, FUNCT_ADD, 1, 0);
    checkOutput("stale_done_2", outs(), 0);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("idle_after_reset", outs(), 0);
    applyStimulus(1, 0, FUNCT_ADD, 0, 0);
    checkOutput("fetch_after_reset", outs(), ctl(1,0,0,0,0,0,0,1,0,0));
    checkOutput("count_after_reset", instr_count, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
